// File: rtl/greedy_snake_pkg.sv
// Constants shared by the Greedy Snake BSRAM list writer and walker:
// node layout, position field slices and the walker state encoding.
package greedy_snake_pkg;

    localparam int ADDR_W = 11;

    localparam logic [ADDR_W-1:0] NULL_ADDRESS = 11'd0;

    // Byte offsets inside a 4-byte node; offset 1 is reserved.
    localparam logic [ADDR_W-1:0] OFF_POS     = 11'd0;
    localparam logic [ADDR_W-1:0] OFF_NEXT_HI = 11'd2;
    localparam logic [ADDR_W-1:0] OFF_NEXT_LO = 11'd3;

    localparam int POS_X_MSB = 7;
    localparam int POS_X_LSB = 4;
    localparam int POS_Y_MSB = 3;
    localparam int POS_Y_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_NODE,
        ST_COMMIT,
        ST_ERR
    } walk_state_t;

    function automatic logic [7:0] make_pos(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        p = '0;
        p[POS_X_MSB:POS_X_LSB] = x;
        p[POS_Y_MSB:POS_Y_LSB] = y;
        return p;
    endfunction

endpackage

// File: rtl/greedy_snake_dpb_r_if.sv
// Read-only view of the Gowin_DPB port B used by the list walker.
interface greedy_snake_dpb_r_if;

    logic                              i_b_clk_en;
    logic [greedy_snake_pkg::ADDR_W-1:0] i_b_address;
    logic [7:0]                        o_b_data;

    modport master (
        output i_b_clk_en,
        output i_b_address,
        input  o_b_data
    );

    modport slave (
        input  i_b_clk_en,
        input  i_b_address,
        output o_b_data
    );

endinterface

// File: rtl/greedy_snake_bitmap.sv
// Shadow and committed 16x16 occupancy bitmaps with a registered (x,y) query.
// The shadow copy is built during a walk and copied whole on commit.
module greedy_snake_bitmap
    import greedy_snake_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       set,
    input  logic [7:0] set_pos,
    input  logic       commit,
    input  logic [3:0] qx,
    input  logic [3:0] qy,
    output logic       q_hit
);

    logic [255:0] shadow;
    logic [255:0] committed;

    // Clear and set never coincide: clear happens while pending, set on a node's last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            committed <= '0;
            q_hit     <= 1'b0;
        end else begin
            if (clear) begin
                shadow <= '0;
            end else if (set) begin
                shadow[set_pos] <= 1'b1;
            end
            if (commit) begin
                committed <= shadow;
            end
            q_hit <= committed[make_pos(qx, qy)];
        end
    end

endmodule

// File: rtl/greedy_snake_dpb_r.sv
// Channel-B list walker: follows the snake list in the shared DPB, builds the
// occupancy bitmap and head/collision result. Optional macro: GREEDY_SNAKE_COLLIDE_EN.
module greedy_snake_dpb_r
    import greedy_snake_pkg::*;
#(
    parameter int RD_LATENCY = 3
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              writer_busy,
    input  logic [ADDR_W-1:0] list_head_addr,
    input  logic [ADDR_W-1:0] list_length,
    greedy_snake_dpb_r_if.master dpb,
    output logic              busy,
    output logic              done,
    output logic [7:0]        head_pos,
    output logic              collide,
    output logic              err,
    input  logic [3:0]        qx,
    input  logic [3:0]        qy,
    output logic              q_hit,
    output logic              q_head
);

    localparam logic [2:0] STEP_POS  = 3'(RD_LATENCY);
    localparam logic [2:0] STEP_HI   = 3'(RD_LATENCY + 1);
    localparam logic [2:0] STEP_LAST = 3'(RD_LATENCY + 2);

    walk_state_t       state;
    logic [2:0]        step;
    logic [ADDR_W-1:0] node_addr;
    logic [ADDR_W-1:0] length_q;
    logic [ADDR_W-1:0] count;
    logic [7:0]        pos_q;
    logic [2:0]        next_hi_q;
    logic [7:0]        shadow_head;
    logic              list_nonempty;

    logic              bm_clear;
    logic              node_last;
    logic              bm_commit;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] count_next;

    assign dpb.i_b_clk_en = 1'b1;

    assign bm_clear   = (state == ST_PEND) && !writer_busy;
    assign node_last  = (state == ST_NODE) && (step == STEP_LAST) && !writer_busy;
    assign bm_commit  = (state == ST_COMMIT);
    assign next_addr  = {next_hi_q, dpb.o_b_data};
    assign count_next = count + 11'd1;

    // Walker FSM. done/busy are registered so they change on the edge that
    // enters COMMIT or ERR; the committed set is updated on the edge leaving COMMIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            step            <= '0;
            node_addr       <= '0;
            length_q        <= '0;
            count           <= '0;
            pos_q           <= '0;
            next_hi_q       <= '0;
            shadow_head     <= '0;
            list_nonempty   <= 1'b0;
            head_pos        <= '0;
            dpb.i_b_address <= NULL_ADDRESS;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_PEND;
                        busy  <= 1'b1;
                    end
                end

                ST_PEND: begin
                    if (!writer_busy) begin
                        length_q    <= list_length;
                        node_addr   <= list_head_addr;
                        count       <= '0;
                        shadow_head <= '0;
                        err         <= 1'b0;
                        step        <= '0;
                        if (list_length == '0) begin
                            state <= ST_COMMIT;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state           <= ST_NODE;
                            dpb.i_b_address <= list_head_addr + OFF_POS;
                        end
                    end
                end

                ST_NODE: begin
                    if (writer_busy) begin
                        // The writer is modifying the list: drop this pass and re-latch later.
                        state           <= ST_PEND;
                        step            <= '0;
                        dpb.i_b_address <= NULL_ADDRESS;
                    end else begin
                        step <= step + 3'd1;
                        case (step)
                            3'd0:    dpb.i_b_address <= node_addr + OFF_NEXT_HI;
                            3'd1:    dpb.i_b_address <= node_addr + OFF_NEXT_LO;
                            3'd2:    dpb.i_b_address <= NULL_ADDRESS;
                            default: ;
                        endcase
                        if (step == STEP_POS) begin
                            pos_q <= dpb.o_b_data;
                        end
                        if (step == STEP_HI) begin
                            next_hi_q <= dpb.o_b_data[2:0];
                        end
                        if (step == STEP_LAST) begin
                            step  <= '0;
                            count <= count_next;
                            if (count == '0) begin
                                shadow_head <= pos_q;
                            end
                            if ((next_addr == NULL_ADDRESS) && (count_next == length_q)) begin
                                state <= ST_COMMIT;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else if ((next_addr == NULL_ADDRESS) || (count_next == length_q)) begin
                                state <= ST_ERR;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                err   <= 1'b1;
                            end else begin
                                node_addr       <= next_addr;
                                dpb.i_b_address <= next_addr + OFF_POS;
                            end
                        end
                    end
                end

                ST_COMMIT: begin
                    head_pos      <= shadow_head;
                    list_nonempty <= (count != '0);
                    state         <= start ? ST_PEND : ST_IDLE;
                    busy          <= start;
                end

                ST_ERR: begin
                    state <= start ? ST_PEND : ST_IDLE;
                    busy  <= start;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GREEDY_SNAKE_COLLIDE_EN
    logic shadow_collide;

    // A later node landing on the recorded head marks a self-collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_collide <= 1'b0;
            collide        <= 1'b0;
        end else begin
            if (bm_clear) begin
                shadow_collide <= 1'b0;
            end else if (node_last && (count != '0) && (pos_q == shadow_head)) begin
                shadow_collide <= 1'b1;
            end
            if (bm_commit) begin
                collide <= shadow_collide;
            end
        end
    end
`else
    assign collide = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_head <= 1'b0;
        end else begin
            q_head <= list_nonempty && (make_pos(qx, qy) == head_pos);
        end
    end

    greedy_snake_bitmap u_bitmap (
        .clk     (clk),
        .rst     (rst),
        .clear   (bm_clear),
        .set     (node_last),
        .set_pos (pos_q),
        .commit  (bm_commit),
        .qx      (qx),
        .qy      (qy),
        .q_hit   (q_hit)
    );

endmodule
